// File: rtl/audio_mix_router_pkg.sv
// Shared definitions for the audio mixer: control FSM state encoding and
// the saturation limits of a signed sample of a given width.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    STEADY = 2'd0,
    RAMP   = 2'd1,
    MUTED  = 2'd2
  } mix_state_e;

  // Largest representable value of a dw-bit two's-complement sample.
  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  // Most negative representable value of a dw-bit two's-complement sample.
  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/audio_mix_router_if.sv
// Sample/control bus of the audio mixer.
//   slave  : mixer side (samples, enables, gains, mute, clip clear in;
//            mix, mix strobe, clip, muted, ramp busy out)
//   master : driver side (mirror image)
interface audio_mix_router_if #(
  parameter int NUM_CH  = 4,
  parameter int DATA_WD = 24,
  parameter int GAIN_WD = 8
);
  logic                              sample_valid_i;
  logic [NUM_CH-1:0][DATA_WD-1:0]    sample_i;
  logic [NUM_CH-1:0]                 ch_en_i;
  logic [NUM_CH-1:0][GAIN_WD-1:0]    gain_i;
  logic                              mute_i;
  logic                              clip_clr_i;
  logic signed [DATA_WD-1:0]         mix_o;
  logic                              mix_valid_o;
  logic                              clip_o;
  logic                              muted_o;
  logic                              ramp_busy_o;

  modport slave (
    input  sample_valid_i, sample_i, ch_en_i, gain_i, mute_i, clip_clr_i,
    output mix_o, mix_valid_o, clip_o, muted_o, ramp_busy_o
  );

  modport master (
    output sample_valid_i, sample_i, ch_en_i, gain_i, mute_i, clip_clr_i,
    input  mix_o, mix_valid_o, clip_o, muted_o, ramp_busy_o
  );
endinterface

// File: rtl/audio_mix_router_gain_ramp.sv
// One channel's applied gain. On every accepted sample the gain walks
// toward its target by at most RAMP_STEP, never overshooting.
//   clk_i, rst_i : clock, synchronous active-high reset (gain -> 0)
//   step_en_i    : sample strobe; the only cycles the gain may move
//   tgt_i        : target gain
//   g_cur_o      : gain applied to the sample accepted this cycle
//   at_tgt_o     : post-update gain equals target
//   zero_o       : post-update gain is zero
module gain_ramp #(
  parameter int GAIN_WD   = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               step_en_i,
  input  logic [GAIN_WD-1:0] tgt_i,
  output logic [GAIN_WD-1:0] g_cur_o,
  output logic               at_tgt_o,
  output logic               zero_o
);

  // A step larger than the gain range behaves as an immediate jump.
  localparam int GMAX = (1 << GAIN_WD) - 1;
  localparam logic [GAIN_WD-1:0] STEP =
    GAIN_WD'((RAMP_STEP > GMAX) ? GMAX : RAMP_STEP);

  logic [GAIN_WD-1:0] g_cur_q, g_cur_d, diff;

  always_comb begin
    g_cur_d = g_cur_q;
    diff    = '0;
    if (step_en_i) begin
      if (tgt_i > g_cur_q) begin
        diff    = tgt_i - g_cur_q;
        g_cur_d = (diff > STEP) ? g_cur_q + STEP : tgt_i;
      end else if (tgt_i < g_cur_q) begin
        diff    = g_cur_q - tgt_i;
        g_cur_d = (diff > STEP) ? g_cur_q - STEP : tgt_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) g_cur_q <= '0;
    else       g_cur_q <= g_cur_d;
  end

  assign g_cur_o  = g_cur_q;
  assign at_tgt_o = (g_cur_d == tgt_i);
  assign zero_o   = (g_cur_d == '0);

endmodule

// File: rtl/audio_mix_router.sv
// N-channel audio mixer with per-channel enable and click-free gain ramps.
// Three-stage pipeline (weight, sum, shift+saturate) accepting one sample
// strobe per cycle; sticky clip flag; STEADY/RAMP/MUTED control FSM.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : sample/control bus (slave side), see audio_mix_router_if
module audio_mix_router
  import audio_mix_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_WD   = 24,
  parameter int GAIN_WD   = 8,
  parameter int GAIN_FRAC = 6,
  parameter int RAMP_STEP = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  audio_mix_router_if.slave   bus
);

  localparam int PROD_W = DATA_WD + GAIN_WD + 1;
  localparam int SUM_W  = PROD_W + $clog2(NUM_CH);

  logic [NUM_CH-1:0][GAIN_WD-1:0] tgt, g_cur;
  logic [NUM_CH-1:0]              at_tgt, zero;
  logic                           all_at, all_zero;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      tgt[c] = (bus.ch_en_i[c] && !bus.mute_i) ? bus.gain_i[c] : '0;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    gain_ramp #(.GAIN_WD(GAIN_WD), .RAMP_STEP(RAMP_STEP)) u_ramp (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .step_en_i (bus.sample_valid_i),
      .tgt_i     (tgt[gi]),
      .g_cur_o   (g_cur[gi]),
      .at_tgt_o  (at_tgt[gi]),
      .zero_o    (zero[gi])
    );
  end

  assign all_at   = &at_tgt;
  assign all_zero = &zero;

  function automatic logic sat_hit(input logic signed [SUM_W-1:0] v);
    return (longint'(v) > sat_max(DATA_WD)) || (longint'(v) < sat_min(DATA_WD));
  endfunction

  function automatic logic signed [DATA_WD-1:0] sat_val(input logic signed [SUM_W-1:0] v);
    if (longint'(v) > sat_max(DATA_WD))      return DATA_WD'(sat_max(DATA_WD));
    else if (longint'(v) < sat_min(DATA_WD)) return DATA_WD'(sat_min(DATA_WD));
    else                                     return DATA_WD'(v);
  endfunction

  // ---- S1: per-channel product, using the gain before this strobe's step
  logic signed [PROD_W-1:0] prod_d    [NUM_CH];
  logic signed [PROD_W-1:0] prod_p1_q [NUM_CH];
  logic                     vld_p1_q;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      prod_d[c] = PROD_W'($signed(bus.sample_i[c])) *
                  PROD_W'($signed({1'b0, g_cur[c]}));
  end

  always_ff @(posedge clk_i) begin
    prod_p1_q <= prod_d;
    if (rst_i) vld_p1_q <= 1'b0;
    else       vld_p1_q <= bus.sample_valid_i;
  end

  // ---- S2: sum across channels with guard bits
  logic signed [SUM_W-1:0] sum_d, sum_p2_q;
  logic                    vld_p2_q;

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NUM_CH; c++)
      sum_d = sum_d + SUM_W'(prod_p1_q[c]);
  end

  always_ff @(posedge clk_i) begin
    sum_p2_q <= sum_d;
    if (rst_i) vld_p2_q <= 1'b0;
    else       vld_p2_q <= vld_p1_q;
  end

  // ---- S3: floor shift, saturate, sticky clip
  logic signed [SUM_W-1:0]   shifted;
  logic signed [DATA_WD-1:0] mix_q;
  logic                      mix_vld_q, clip_q;

  assign shifted = sum_p2_q >>> GAIN_FRAC;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mix_q     <= '0;
      mix_vld_q <= 1'b0;
      clip_q    <= 1'b0;
    end else begin
      mix_vld_q <= vld_p2_q;
      if (vld_p2_q) mix_q <= sat_val(shifted);
      // A fresh saturation beats a simultaneous clear.
      if (vld_p2_q && sat_hit(shifted)) clip_q <= 1'b1;
      else if (bus.clip_clr_i)          clip_q <= 1'b0;
    end
  end

  // ---- Control FSM, judged on the post-step gains
  mix_state_e state_q, state_d;
  logic       busy_q, muted_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      STEADY: if (!all_at)                       state_d = RAMP;
              else if (bus.mute_i && all_zero)   state_d = MUTED;
      RAMP:   if (all_at && !bus.mute_i)         state_d = STEADY;
              else if (all_zero && bus.mute_i)   state_d = MUTED;
      MUTED:  if (!bus.mute_i || !all_at)        state_d = RAMP;
      default:                                   state_d = STEADY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STEADY;
      busy_q  <= 1'b0;
      muted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RAMP);
      muted_q <= (state_d == MUTED);
    end
  end

  assign bus.mix_o       = mix_q;
  assign bus.mix_valid_o = mix_vld_q;
  assign bus.clip_o      = clip_q;
  assign bus.muted_o     = muted_q;
  assign bus.ramp_busy_o = busy_q;

endmodule

// File: tb/tb_audio_mix_router.sv
module tb_audio_mix_router;
  localparam int NUM_CH    = 4;
  localparam int DATA_WD   = 24;
  localparam int GAIN_WD   = 8;
  localparam int GAIN_FRAC = 6;
  localparam int RAMP_STEP = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_mix_router_if #(.NUM_CH(NUM_CH), .DATA_WD(DATA_WD), .GAIN_WD(GAIN_WD)) bus();

  audio_mix_router #(
    .NUM_CH(NUM_CH), .DATA_WD(DATA_WD), .GAIN_WD(GAIN_WD),
    .GAIN_FRAC(GAIN_FRAC), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int due; } exp_t;
  exp_t sbq[$];

  typedef struct { int s0; int s1; int s2; int s3; int exp; } vec_t;
  vec_t vecs[8];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every mix strobe must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (!rst && bus.mix_valid_o) begin
      exp_t e;
      check("sb_nonempty", longint'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("mix_value", longint'(bus.mix_o), e.val);
        check("mix_latency", cyc, e.due);
      end
    end
  end

  task automatic strobe(input int s0, input int s1, input int s2, input int s3,
                        input bit expect_out, input int exp_val);
    @(posedge clk); #1;
    bus.sample_i[0]    = DATA_WD'(s0);
    bus.sample_i[1]    = DATA_WD'(s1);
    bus.sample_i[2]    = DATA_WD'(s2);
    bus.sample_i[3]    = DATA_WD'(s3);
    bus.sample_valid_i = 1'b1;
    if (expect_out) sbq.push_back('{exp_val, cyc + 3});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.sample_valid_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // mix = s0 + s1/2 + s2 + s3/4 (floored) with gains 64/32/64/16
    vecs[0] = '{100, 0, 0, 0, 100};
    vecs[1] = '{0, 100, 0, 0, 50};
    vecs[2] = '{0, 0, -7, 0, -7};
    vecs[3] = '{0, 0, 0, 5, 1};
    vecs[4] = '{0, 0, 0, -5, -2};
    vecs[5] = '{0, -3, 0, 0, -2};
    vecs[6] = '{4000000, 4000000, 4000000, 0, 8388607};
    vecs[7] = '{-1, -1, -1, -1, -3};

    bus.sample_valid_i = 1'b0;
    bus.sample_i       = '0;
    bus.ch_en_i        = '0;
    bus.gain_i         = '0;
    bus.mute_i         = 1'b0;
    bus.clip_clr_i     = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mix", longint'(bus.mix_o), 0);
    check("rst_mix_valid", bus.mix_valid_o, 0);
    check("rst_clip", bus.clip_o, 0);
    check("rst_muted", bus.muted_o, 0);
    check("rst_busy", bus.ramp_busy_o, 0);

    // 1. Ramp-up from reset
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ch_en_i   = 4'b0001;
    bus.gain_i[0] = 8'd64;
    @(posedge clk); @(negedge clk);
    check("t1_busy_on", bus.ramp_busy_o, 1);
    idle(3);
    @(negedge clk);
    check("t1_busy_hold_no_strobe", bus.ramp_busy_o, 1);
    strobe(1000, 0, 0, 0, 1, 0);
    strobe(1000, 0, 0, 0, 1, 1000);
    idle(1);
    @(negedge clk);
    check("t1_busy_off", bus.ramp_busy_o, 0);
    idle(4);

    // 2. Saturation and sticky clip
    bus.ch_en_i   = 4'b0011;
    bus.gain_i[1] = 8'd64;
    strobe(0, 0, 0, 0, 1, 0);
    strobe(8388607, 8388607, 0, 0, 1, 8388607);
    idle(4);
    @(negedge clk);
    check("t2_clip_set", bus.clip_o, 1);
    strobe(-8388608, -8388608, 0, 0, 1, -8388608);
    strobe(100, 200, 0, 0, 1, 300);
    idle(4);
    @(negedge clk);
    check("t2_clip_sticky", bus.clip_o, 1);
    @(posedge clk); #1;
    bus.clip_clr_i = 1'b1;
    idle(1);
    bus.clip_clr_i = 1'b0;
    @(negedge clk);
    check("t2_clip_cleared", bus.clip_o, 0);

    // 6. Saturation landing in S3 together with clip_clr: set wins
    strobe(8388607, 8388607, 0, 0, 1, 8388607);
    idle(2);
    @(negedge clk);
    check("t6_clip_before", bus.clip_o, 0);
    bus.clip_clr_i = 1'b1;
    idle(1);
    bus.clip_clr_i = 1'b0;
    @(negedge clk);
    check("t6_clip_set_wins", bus.clip_o, 1);
    idle(3);

    // 3. Mute at gain 128
    bus.ch_en_i   = 4'b0001;
    bus.gain_i[0] = 8'd128;
    bus.gain_i[1] = 8'd0;
    strobe(1000, 0, 0, 0, 1, 1000);
    strobe(1000, 0, 0, 0, 1, 2000);
    idle(1);
    @(negedge clk);
    check("t3_steady_busy", bus.ramp_busy_o, 0);
    check("t3_steady_muted", bus.muted_o, 0);
    bus.mute_i = 1'b1;
    strobe(1000, 0, 0, 0, 1, 2000);
    idle(1);
    @(negedge clk);
    check("t3_half_muted", bus.muted_o, 0);
    check("t3_half_busy", bus.ramp_busy_o, 1);
    strobe(1000, 0, 0, 0, 1, 1000);
    idle(1);
    @(negedge clk);
    check("t3_muted", bus.muted_o, 1);
    check("t3_muted_busy", bus.ramp_busy_o, 0);
    strobe(1000, 0, 0, 0, 1, 0);
    strobe(-5000, 0, 0, 0, 1, 0);
    idle(4);
    bus.mute_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t3_unmute_busy", bus.ramp_busy_o, 1);
    check("t3_unmute_muted", bus.muted_o, 0);
    strobe(1000, 0, 0, 0, 1, 0);
    strobe(-1000, 0, 0, 0, 1, -1000);
    idle(1);
    @(negedge clk);
    check("t3_resteady", bus.ramp_busy_o, 0);
    idle(3);

    // 4. Back-to-back table with steady gains
    bus.ch_en_i   = 4'b1111;
    bus.gain_i[0] = 8'd64;
    bus.gain_i[1] = 8'd32;
    bus.gain_i[2] = 8'd64;
    bus.gain_i[3] = 8'd16;
    strobe(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      strobe(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, 1, vecs[i].exp);
    idle(1);
    @(negedge clk);
    check("t4_busy", bus.ramp_busy_o, 0);
    idle(5);

    // 5. Reset during a ramp with two samples in flight
    bus.gain_i[0] = 8'd200;
    strobe(1000, 0, 0, 0, 0, 0);
    strobe(1000, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.sample_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_mix", longint'(bus.mix_o), 0);
    check("t5_mix_valid", bus.mix_valid_o, 0);
    check("t5_clip", bus.clip_o, 0);
    check("t5_muted", bus.muted_o, 0);
    check("t5_busy", bus.ramp_busy_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t5_no_stale_valid", bus.mix_valid_o, 0);
    end
    strobe(1000, 1000, 1000, 1000, 1, 0);
    idle(6);

    check("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
